// File: rtl/ppc_types.sv
// rtl/ppc_types.sv - shared PowerPC execution-cluster types for the divide unit
package ppc_types;

    localparam int XER_SO_BIT = 31;
    localparam int XER_OV_BIT = 30;

    typedef struct packed {
        logic div_signed;
        logic alter_OV;
        logic alter_CR0;
    } div_decode_t;

    typedef struct packed {
        logic [31:0] xer;
        logic        so;
        logic        xer_valid;
        logic        cr0_valid;
    } cond_exception_t;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_BUSY,
        CORE_DONE
    } core_state_t;

    // Most-negative two's-complement value for an xlen-bit word (xlen <= 64)
    function automatic logic [63:0] most_negative(input int unsigned xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring divider retiring BITS_PER_CYCLE quotient bits per cycle
module div_iter_core
    import ppc_types::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER) + 1;

    if ((XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_split
        $error("div_iter_core: XLEN must be a multiple of BITS_PER_CYCLE");
    end
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
        $error("div_iter_core: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    core_state_t     state, state_n;
    logic [XLEN:0]   acc, acc_n;
    logic [XLEN-1:0] q, q_n;
    logic [XLEN-1:0] dvsr;
    logic [CW-1:0]   cnt;

    // Unrolled compare/subtract/shift steps for one iteration; q shifts the dividend out as quotient bits shift in
    always_comb begin
        acc_n = acc;
        q_n   = q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            acc_n = {acc_n[XLEN-1:0], q_n[XLEN-1]};
            q_n   = {q_n[XLEN-2:0], 1'b0};
            if (acc_n >= {1'b0, dvsr}) begin
                acc_n = acc_n - {1'b0, dvsr};
                q_n[0] = 1'b1;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state <= CORE_IDLE;
        else     state <= state_n;
    end

    // Next state: a finished result is held until the owner releases it
    always_comb begin
        state_n = state;
        case (state)
            CORE_IDLE: if (start) state_n = CORE_BUSY;
            CORE_BUSY: if (cnt == CW'(ITER - 1)) state_n = CORE_DONE;
            CORE_DONE: begin
                if (start)      state_n = CORE_BUSY;
                else if (!hold) state_n = CORE_IDLE;
            end
            default:   state_n = CORE_IDLE;
        endcase
    end

    // Datapath: load operands on start, iterate while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            dvsr <= '0;
            cnt  <= '0;
        end else if (start) begin
            acc  <= '0;
            q    <= dividend;
            dvsr <= divisor;
            cnt  <= '0;
        end else if (state == CORE_BUSY) begin
            acc  <= acc_n;
            q    <= q_n;
            cnt  <= cnt + CW'(1);
        end
    end

    assign done      = (state == CORE_DONE);
    assign quotient  = q;
    assign remainder = acc[XLEN-1:0];

endmodule

// File: rtl/div_unit_radix.sv
// rtl/div_unit_radix.sv - pipelined signed/unsigned integer divide unit with remainder mode and flush
module div_unit_radix
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH    = 5,
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [XLEN-1:0]        op1,
    input  logic [XLEN-1:0]        op2,
    input  logic [31:0]            xer,
    input  div_decode_t            control,
    input  logic                   rem_mode,
    input  logic                   flush,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [XLEN-1:0]        result,
    output cond_exception_t        cr0_xer
);

    if (XLEN < 8) begin : g_bad_xlen
        $error("div_unit_radix: XLEN must be at least 8");
    end

    localparam logic [63:0]     MIN_NEG_W = most_negative(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG   = MIN_NEG_W[XLEN-1:0];

    // S0: raw operands
    logic                   s0_v;
    logic [XLEN-1:0]        s0_op1, s0_op2;
    logic [31:0]            s0_xer;
    div_decode_t            s0_ctrl;
    logic                   s0_rem;
    logic [RS_ID_WIDTH-1:0] s0_rs;
    logic [4:0]             s0_addr;

    // S1: sign-magnitude operands
    logic                   s1_v;
    logic [XLEN-1:0]        s1_mag1, s1_mag2;
    logic                   s1_neg, s1_special, s1_rem;
    logic [31:0]            s1_xer;
    div_decode_t            s1_ctrl;
    logic [RS_ID_WIDTH-1:0] s1_rs;
    logic [4:0]             s1_addr;

    // Core slot: metadata of the op owning the iterative core
    logic                   c_v;
    logic                   c_neg, c_special, c_rem;
    logic [31:0]            c_xer;
    div_decode_t            c_ctrl;
    logic [RS_ID_WIDTH-1:0] c_rs;
    logic [4:0]             c_addr;

    logic                   kill;
    logic                   accept, s0_adv, s1_adv;
    logic                   c_fin, out_load, c_free;
    logic                   core_start, core_hold, core_done;
    logic [XLEN-1:0]        core_quo, core_remd;

    logic                   neg1, neg2, special_s0;
    logic [XLEN-1:0]        mag1, mag2;

    logic [XLEN-1:0]        raw_res, res_next;
    logic [31:0]            xer_next;

    assign kill = rst | flush;

    // Stage handshakes: a slot advances when it holds an op and the next slot is free or freeing
    always_comb begin
        c_fin       = c_v & (c_special | core_done);
        out_load    = (!output_valid & c_fin) | (output_valid & output_ready);
        c_free      = c_fin & out_load;
        s1_adv      = s1_v & !c_v;
        s0_adv      = s0_v & (!s1_v | s1_adv);
        input_ready = !(s0_v & s1_v & c_v);
        accept      = input_valid & input_ready & !flush;
        core_start  = s1_adv & !s1_special & !flush;
        core_hold   = c_v & !c_free;
    end

    // Operand sign stripping and detection of ops that skip the iteration
    always_comb begin
        neg1       = s0_ctrl.div_signed & s0_op1[XLEN-1];
        neg2       = s0_ctrl.div_signed & s0_op2[XLEN-1];
        mag1       = neg1 ? (~s0_op1 + 1'b1) : s0_op1;
        mag2       = neg2 ? (~s0_op2 + 1'b1) : s0_op2;
        special_s0 = (s0_op2 == '0) |
                     (s0_ctrl.div_signed & (s0_op1 == MIN_NEG) & (s0_op2 == '1));
    end

    // S0 operand register
    always_ff @(posedge clk) begin
        if (kill) begin
            s0_v <= 1'b0;
        end else if (accept) begin
            s0_v    <= 1'b1;
            s0_op1  <= op1;
            s0_op2  <= op2;
            s0_xer  <= xer;
            s0_ctrl <= control;
            s0_rem  <= rem_mode;
            s0_rs   <= rs_id_in;
            s0_addr <= result_reg_addr_in;
        end else if (s0_adv) begin
            s0_v <= 1'b0;
        end
    end

    // S1 sign-magnitude register; remainder takes the dividend's sign, quotient the xor of both
    always_ff @(posedge clk) begin
        if (kill) begin
            s1_v <= 1'b0;
        end else if (s0_adv) begin
            s1_v       <= 1'b1;
            s1_mag1    <= mag1;
            s1_mag2    <= mag2;
            s1_neg     <= s0_rem ? neg1 : (neg1 ^ neg2);
            s1_special <= special_s0;
            s1_rem     <= s0_rem;
            s1_xer     <= s0_xer;
            s1_ctrl    <= s0_ctrl;
            s1_rs      <= s0_rs;
            s1_addr    <= s0_addr;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    // Core slot ownership; a special op occupies the slot for one cycle without iterating
    always_ff @(posedge clk) begin
        if (kill) begin
            c_v <= 1'b0;
        end else if (s1_adv) begin
            c_v       <= 1'b1;
            c_neg     <= s1_neg;
            c_special <= s1_special;
            c_rem     <= s1_rem;
            c_xer     <= s1_xer;
            c_ctrl    <= s1_ctrl;
            c_rs      <= s1_rs;
            c_addr    <= s1_addr;
        end else if (c_free) begin
            c_v <= 1'b0;
        end
    end

    div_iter_core #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk       (clk),
        .rst       (kill),
        .start     (core_start),
        .hold      (core_hold),
        .dividend  (s1_mag1),
        .divisor   (s1_mag2),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_remd)
    );

    // Result sign restoration and XER overflow update
    always_comb begin
        raw_res  = c_rem ? core_remd : core_quo;
        res_next = c_special ? '0 : (c_neg ? (~raw_res + 1'b1) : raw_res);
        xer_next = c_xer;
        if (c_ctrl.alter_OV) begin
            xer_next[XER_OV_BIT] = c_special;
            xer_next[XER_SO_BIT] = c_xer[XER_SO_BIT] | c_special;
        end
    end

    // Output register; holds steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (kill) begin
            output_valid        <= 1'b0;
            result              <= '0;
            rs_id_out           <= '0;
            result_reg_addr_out <= '0;
            cr0_xer             <= '0;
        end else if (out_load) begin
            output_valid <= c_fin;
            if (c_fin) begin
                result              <= res_next;
                rs_id_out           <= c_rs;
                result_reg_addr_out <= c_addr;
                cr0_xer.xer         <= xer_next;
                cr0_xer.so          <= xer_next[XER_SO_BIT];
                cr0_xer.xer_valid   <= c_ctrl.alter_OV;
                cr0_xer.cr0_valid   <= c_ctrl.alter_CR0;
            end
        end
    end

endmodule

// File: tb/tb_div_unit_radix.sv
// tb/tb_div_unit_radix.sv - self-checking bench for div_unit_radix
module tb_div_unit_radix;
    import ppc_types::*;

    typedef struct packed {
        logic [31:0]     res;
        cond_exception_t cx;
        logic [4:0]      rs;
        logic [4:0]      addr;
    } exp_t;

    logic            clk, rst, flush;
    logic [4:0]      rs_id, addr;
    logic [31:0]     op1, op2, xer;
    div_decode_t     ctrl;
    logic            rem_mode;

    logic            iv4, ir4, ov4, or4;
    logic [4:0]      rs_o4, addr_o4;
    logic [31:0]     res4;
    cond_exception_t cx4;

    logic            iv1, ir1, ov1, or1;
    logic [4:0]      rs_o1, addr_o1;
    logic [31:0]     res1;
    cond_exception_t cx1;

    exp_t            sb[$];
    int              vectors;
    int              miscompares;
    bit              last_in;

    div_unit_radix #(.RS_ID_WIDTH(5), .XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .input_valid(iv4), .input_ready(ir4),
        .rs_id_in(rs_id), .result_reg_addr_in(addr), .op1(op1), .op2(op2),
        .xer(xer), .control(ctrl), .rem_mode(rem_mode), .flush(flush),
        .output_valid(ov4), .output_ready(or4), .rs_id_out(rs_o4),
        .result_reg_addr_out(addr_o4), .result(res4), .cr0_xer(cx4)
    );

    div_unit_radix #(.RS_ID_WIDTH(5), .XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .input_valid(iv1), .input_ready(ir1),
        .rs_id_in(rs_id), .result_reg_addr_in(addr), .op1(op1), .op2(op2),
        .xer(xer), .control(ctrl), .rem_mode(rem_mode), .flush(1'b0),
        .output_valid(ov1), .output_ready(or1), .rs_id_out(rs_o1),
        .result_reg_addr_out(addr_o1), .result(res1), .cr0_xer(cx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] x_in,
                                   input div_decode_t c, input logic rm,
                                   input logic [4:0] rs, input logic [4:0] ad);
        exp_t               e;
        logic signed [31:0] sa, sbv;
        logic [31:0]        r, x;
        logic               ov;
        sa  = a;
        sbv = b;
        ov  = 1'b0;
        if (b == 32'd0 || (c.div_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            ov = 1'b1;
            r  = 32'd0;
        end else if (c.div_signed) begin
            r = rm ? 32'(sa % sbv) : 32'(sa / sbv);
        end else begin
            r = rm ? (a % b) : (a / b);
        end
        x = x_in;
        if (c.alter_OV) begin
            x[30] = ov;
            x[31] = x_in[31] | ov;
        end
        e.res          = r;
        e.cx.xer       = x;
        e.cx.so        = x[31];
        e.cx.xer_valid = c.alter_OV;
        e.cx.cr0_valid = c.alter_CR0;
        e.rs           = rs;
        e.addr         = ad;
        return e;
    endfunction

    // One clock of the 4-bit-per-cycle unit: called just after a negedge with inputs set
    task automatic cycle();
        exp_t e;
        bit   in_fire, out_fire;
        #1;
        in_fire  = iv4 && ir4;
        out_fire = ov4 && or4;
        if (out_fire) begin
            if (sb.size() == 0) begin
                chk("extra_result", 64'(res4), 64'hDEAD_0000_0000);
            end else begin
                e = sb.pop_front();
                chk("result", 64'(res4), 64'(e.res));
                chk("cr0_xer", 64'(cx4), 64'(e.cx));
                chk("rs_id_out", 64'(rs_o4), 64'(e.rs));
                chk("reg_addr_out", 64'(addr_o4), 64'(e.addr));
            end
        end
        if (in_fire) sb.push_back(model(op1, op2, xer, ctrl, rem_mode, rs_id, addr));
        last_in = in_fire;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                          input logic rm, input logic [31:0] x);
        op1      = a;
        op2      = b;
        ctrl     = div_decode_t'(c);
        rem_mode = rm;
        xer      = x;
        rs_id    = 5'($urandom);
        addr     = 5'($urandom);
    endtask

    task automatic send();
        int k;
        iv4 = 1'b1;
        k   = 0;
        last_in = 1'b0;
        while (!last_in && k < 200) begin
            cycle();
            k++;
        end
        if (!last_in) chk("send_timeout", 64'(k), 64'd0);
        iv4 = 1'b0;
    endtask

    task automatic drain();
        int k;
        or4 = 1'b1;
        k   = 0;
        while (sb.size() > 0 && k < 400) begin
            cycle();
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic lat4(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic rm, input logic [31:0] x,
                        output int lat, output logic [31:0] r, output cond_exception_t cx);
        set_op(a, b, c, rm, x);
        or4 = 1'b1;
        iv4 = 1'b1;
        cycle();
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 200) begin
            cycle();
            lat++;
        end
        r  = res4;
        cx = cx4;
        cycle();
    endtask

    task automatic kill_case(input bit use_rst, input string tag);
        int k;
        or4 = 1'b0;
        set_op(32'd1000, 32'd3, 3'b000, 1'b0, 32'd0);
        send();
        k = 0;
        while (!ov4 && k < 60) begin
            cycle();
            k++;
        end
        chk({tag, "_first_done"}, 64'(ov4), 64'd1);
        set_op(32'd5555, 32'd11, 3'b100, 1'b1, 32'd0);
        send();
        repeat (4) cycle();
        set_op(32'd77, 32'd5, 3'b000, 1'b0, 32'd0);
        iv4 = 1'b1;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_output_valid"}, 64'(ov4), 64'd0);
        chk({tag, "_input_ready"}, 64'(ir4), 64'd1);
        chk({tag, "_result"}, 64'(res4), 64'd0);
        chk({tag, "_cr0_xer"}, 64'(cx4), 64'd0);
        chk({tag, "_rs_addr"}, 64'({rs_o4, addr_o4}), 64'd0);
        rst   = 1'b0;
        flush = 1'b0;
        iv4   = 1'b0;
        sb.delete();
        @(negedge clk);
        or4 = 1'b1;
        repeat (20) cycle();
        set_op(32'hFFFF_FF00, 32'd16, 3'b110, 1'b0, 32'h2000_0000);
        send();
        drain();
    endtask

    initial begin
        int              lat, k, sent;
        logic [31:0]     r, snap;
        cond_exception_t cx;

        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; flush = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; iv1 = 1'b0; or1 = 1'b1;
        set_op(32'd0, 32'd1, 3'b000, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_output_valid", 64'(ov4), 64'd0);
        chk("rst_input_ready", 64'(ir4), 64'd1);
        chk("rst_result", 64'(res4), 64'd0);
        chk("rst_cr0_xer", 64'(cx4), 64'd0);
        chk("rst_dut1_valid", 64'(ov1), 64'd0);

        // divwu 100/7 on the radix-2 unit
        set_op(32'd100, 32'd7, 3'b010, 1'b0, 32'd0);
        iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        k = 0;
        while (!ov1 && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("bpc1_latency", 64'(k), 64'd35);
        chk("bpc1_result", 64'(res1), 64'd14);
        chk("bpc1_ov", 64'(cx1.xer[30]), 64'd0);
        chk("bpc1_xer_valid", 64'(cx1.xer_valid), 64'd1);
        @(posedge clk);
        @(negedge clk);

        // Signed -100/7 and remainder on the 4-bit-per-cycle unit
        lat4(32'hFFFF_FF9C, 32'd7, 3'b100, 1'b0, 32'd0, lat, r, cx);
        chk("divw_latency", 64'(lat), 64'd11);
        chk("divw_result", 64'(r), 64'hFFFF_FFF2);
        lat4(32'hFFFF_FF9C, 32'd7, 3'b100, 1'b1, 32'd0, lat, r, cx);
        chk("modsw_latency", 64'(lat), 64'd11);
        chk("modsw_result", 64'(r), 64'hFFFF_FFFE);

        // Most-negative / -1 overflow
        lat4(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0, 32'd0, lat, r, cx);
        chk("ovf_latency", 64'(lat), 64'd3);
        chk("ovf_result", 64'(r), 64'd0);
        chk("ovf_ov", 64'(cx.xer[30]), 64'd1);
        chk("ovf_so", 64'(cx.so), 64'd1);
        chk("ovf_xer_valid", 64'(cx.xer_valid), 64'd1);

        // Divide by zero without alter_OV
        lat4(32'd1234, 32'd0, 3'b000, 1'b0, 32'h8000_0000, lat, r, cx);
        chk("dz_latency", 64'(lat), 64'd3);
        chk("dz_result", 64'(r), 64'd0);
        chk("dz_xer", 64'(cx.xer), 64'h8000_0000);
        chk("dz_xer_valid", 64'(cx.xer_valid), 64'd0);

        // Three back-to-back ops into a stalled consumer
        or4 = 1'b0;
        set_op(32'd900, 32'd9, 3'b000, 1'b0, 32'd0);
        send();
        set_op(32'hFFFF_F000, 32'd3, 3'b100, 1'b1, 32'd0);
        send();
        set_op(32'd65535, 32'd255, 3'b001, 1'b0, 32'd0);
        send();
        chk("b2b_ready_drop", 64'(ir4), 64'd0);
        snap = 32'd0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) snap = res4;
            cycle();
        end
        chk("stall_valid", 64'(ov4), 64'd1);
        chk("stall_stable", 64'(res4), 64'(snap));
        drain();

        // Kill mid-iteration, by flush then by reset
        kill_case(1'b0, "flush");
        kill_case(1'b1, "reset");

        // Randomised stream with random consumer back-pressure
        sent = 0;
        for (int c = 0; c < 8000 && (sent < 150 || sb.size() > 0); c++) begin
            if (!iv4 && sent < 150 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 5))
                    0:       set_op($urandom, 32'd0, 3'($urandom), 1'($urandom), $urandom);
                    1:       set_op(32'h8000_0000, 32'hFFFF_FFFF, 3'($urandom), 1'($urandom), $urandom);
                    2:       set_op($urandom, 32'($urandom_range(1, 255)), 3'($urandom), 1'($urandom), $urandom);
                    3:       set_op(32'($urandom_range(0, 50)), $urandom, 3'($urandom), 1'($urandom), $urandom);
                    default: set_op($urandom, $urandom, 3'($urandom), 1'($urandom), $urandom);
                endcase
                iv4 = 1'b1;
            end
            or4 = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_in) begin
                iv4 = 1'b0;
                sent++;
            end
        end
        chk("random_sent", 64'(sent), 64'd150);
        chk("random_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
